// File: rtl/uart_frame_parser.sv
// Purpose : frames SOF/LEN/payload/CHK byte streams from the UART receiver, verifies the checksum and replays verified payloads.
// Latency : the CHK byte strobed in cycle N gives o_frame_ok and payload byte 0 on o_data in cycle N+1; error pulses follow the offending byte by one cycle.
// Backpress: none toward the receiver (bytes arriving during DRAIN are dropped with o_overrun); the consumer stalls DRAIN with i_ready=0.
//
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_data, i_valid              received byte and its one-cycle strobe
//   o_data, o_valid, o_last      payload replay toward the consumer, i_ready accepts
//   o_frame_len                  LEN of the most recent verified frame
//   o_frame_ok, o_err_len,
//   o_err_chk, o_err_timeout,
//   o_overrun                    one-cycle status pulses
module uart_frame_parser #(
    parameter int           MAX_LEN      = 16,
    parameter logic [7:0]   SOF          = 8'hA5,
    parameter int           TIMEOUT_CLKS = 52080
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [7:0]                   i_data,
    input  logic                         i_valid,
    output logic [7:0]                   o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_last,
    output logic [$clog2(MAX_LEN+1)-1:0] o_frame_len,
    output logic                         o_frame_ok,
    output logic                         o_err_len,
    output logic                         o_err_chk,
    output logic                         o_err_timeout,
    output logic                         o_overrun
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

    state_t         r_state, w_state_nxt;
    logic [LW-1:0]  r_len, w_len_nxt;
    logic [7:0]     r_sum, w_sum_nxt;
    logic [IW-1:0]  r_wr_idx, w_wr_idx_nxt;
    logic [IW-1:0]  r_rd_idx, w_rd_idx_nxt;
    logic [TW-1:0]  r_timer, w_timer_nxt;
    logic [LW-1:0]  r_frame_len, w_frame_len_nxt;
    logic           r_frame_ok, w_frame_ok_nxt;
    logic           r_err_len, w_err_len_nxt;
    logic           r_err_chk, w_err_chk_nxt;
    logic           r_err_timeout, w_err_timeout_nxt;
    logic           r_overrun, w_overrun_nxt;
    logic           w_buf_we;
    logic           w_timed;
    logic           w_timeout;
    logic           w_drain;
    logic           w_rd_last;

    // Payload buffer has no reset: it is only read in DRAIN, after being written.
    logic [7:0]     r_buf [MAX_LEN];

    always_ff @(posedge i_clk) begin
        if (w_buf_we) begin
            r_buf[r_wr_idx] <= i_data;
        end
    end

    assign w_drain   = (r_state == S_DRAIN);
    assign w_rd_last = (LW'(r_rd_idx) == r_len - LW'(1));
    assign w_timed   = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    // A byte on the terminal-count cycle takes priority over the timeout.
    assign w_timeout = w_timed && !i_valid && (r_timer == TW'(TIMEOUT_CLKS));

    always_comb begin
        w_state_nxt       = r_state;
        w_len_nxt         = r_len;
        w_sum_nxt         = r_sum;
        w_wr_idx_nxt      = r_wr_idx;
        w_rd_idx_nxt      = r_rd_idx;
        w_frame_len_nxt   = r_frame_len;
        w_frame_ok_nxt    = 1'b0;
        w_err_len_nxt     = 1'b0;
        w_err_chk_nxt     = 1'b0;
        w_err_timeout_nxt = 1'b0;
        w_overrun_nxt     = 1'b0;
        w_buf_we          = 1'b0;

        if (!w_timed || i_valid || w_timeout) begin
            w_timer_nxt = '0;
        end else begin
            w_timer_nxt = r_timer + TW'(1);
        end

        if (w_timeout) begin
            w_state_nxt       = S_HUNT;
            w_err_timeout_nxt = 1'b1;
        end

        case (r_state)
            S_HUNT: begin
                if (i_valid && (i_data == SOF)) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (i_valid) begin
                    if ((i_data == 8'd0) || (i_data > 8'(MAX_LEN))) begin
                        w_err_len_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end else begin
                        w_len_nxt    = i_data[LW-1:0];
                        w_sum_nxt    = i_data;
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_valid) begin
                    w_buf_we     = 1'b1;
                    w_sum_nxt    = r_sum + i_data;
                    w_wr_idx_nxt = r_wr_idx + IW'(1);
                    if (LW'(r_wr_idx) == r_len - LW'(1)) begin
                        w_state_nxt = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_valid) begin
                    if (i_data == r_sum) begin
                        w_frame_ok_nxt  = 1'b1;
                        w_frame_len_nxt = r_len;
                        w_rd_idx_nxt    = '0;
                        w_state_nxt     = S_DRAIN;
                    end else begin
                        w_err_chk_nxt = 1'b1;
                        w_state_nxt   = S_HUNT;
                    end
                end
            end
            S_DRAIN: begin
                // Receiver cannot be stalled, so anything arriving now is lost.
                if (i_valid) begin
                    w_overrun_nxt = 1'b1;
                end
                if (i_ready) begin
                    if (w_rd_last) begin
                        w_state_nxt = S_HUNT;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + IW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_HUNT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_HUNT;
            r_len         <= '0;
            r_sum         <= '0;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_timer       <= '0;
            r_frame_len   <= '0;
            r_frame_ok    <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_len         <= w_len_nxt;
            r_sum         <= w_sum_nxt;
            r_wr_idx      <= w_wr_idx_nxt;
            r_rd_idx      <= w_rd_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_frame_ok    <= w_frame_ok_nxt;
            r_err_len     <= w_err_len_nxt;
            r_err_chk     <= w_err_chk_nxt;
            r_err_timeout <= w_err_timeout_nxt;
            r_overrun     <= w_overrun_nxt;
        end
    end

    // Replay outputs decode registered state only; gated to zero outside DRAIN.
    assign o_valid       = w_drain;
    assign o_data        = w_drain ? r_buf[r_rd_idx] : 8'd0;
    assign o_last        = w_drain && w_rd_last;
    assign o_frame_len   = r_frame_len;
    assign o_frame_ok    = r_frame_ok;
    assign o_err_len     = r_err_len;
    assign o_err_chk     = r_err_chk;
    assign o_err_timeout = r_err_timeout;
    assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Purpose : directed-vector bench for uart_frame_parser with a payload scoreboard and pulse counters.
// Latency : bytes are driven one per cycle; checks sample one time unit after the rising edge or on the falling edge.
// Backpress: i_ready is held high except for one ten-cycle stall in the middle of a 16-byte drain.
module tb_uart_frame_parser;

    localparam int TO = 20;

    typedef struct packed {
        logic       last;
        logic [7:0] dat;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] i_data;
    logic       i_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_last;
    logic [4:0] o_frame_len;
    logic       o_frame_ok;
    logic       o_err_len;
    logic       o_err_chk;
    logic       o_err_timeout;
    logic       o_overrun;

    int checks = 0;
    int errors = 0;
    int n_ok = 0, n_len = 0, n_chk = 0, n_to = 0, n_ovr = 0;
    int exp_ok = 0, exp_len = 0, exp_chk = 0, exp_to = 0, exp_ovr = 0;

    exp_t       sb [$];
    logic [7:0] pl [$];

    uart_frame_parser #(
        .MAX_LEN      (16),
        .SOF          (8'hA5),
        .TIMEOUT_CLKS (TO)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_data        (i_data),
        .i_valid       (i_valid),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .i_ready       (i_ready),
        .o_last        (o_last),
        .o_frame_len   (o_frame_len),
        .o_frame_ok    (o_frame_ok),
        .o_err_len     (o_err_len),
        .o_err_chk     (o_err_chk),
        .o_err_timeout (o_err_timeout),
        .o_overrun     (o_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Monitor: pops the scoreboard on each accepted beat and counts pulse cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            n_ok  += int'(o_frame_ok);
            n_len += int'(o_err_len);
            n_chk += int'(o_err_chk);
            n_to  += int'(o_err_timeout);
            n_ovr += int'(o_overrun);
            if (o_valid && i_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got data=%02h last=%0b, none expected", o_data, o_last);
                end else if ({o_last, o_data} !== {sb[0].last, sb[0].dat}) begin
                    errors++;
                    $display("FAIL beat: got data=%02h last=%0b, want data=%02h last=%0b",
                             o_data, o_last, sb[0].dat, sb[0].last);
                    void'(sb.pop_front());
                end else begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_valid = 1'b1;
        i_data  = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = 8'h00;
    endtask

    // Sends SOF, LEN, the bytes in pl, then CHK; good frames queue their payload.
    task automatic send_frame(input logic [7:0] len, input logic [7:0] ck, input bit good);
        send_byte(8'hA5);
        send_byte(len);
        foreach (pl[i]) begin
            send_byte(pl[i]);
            if (good) begin
                sb.push_back('{last: (i == pl.size() - 1), dat: pl[i]});
            end
        end
        send_byte(ck);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && o_valid; i++) begin
            idle(1);
        end
        chk("drain_done", {31'd0, o_valid}, 32'd0);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_ok"},   n_ok,  exp_ok);
        chk({tag, "_len"},  n_len, exp_len);
        chk({tag, "_chk"},  n_chk, exp_chk);
        chk({tag, "_to"},   n_to,  exp_to);
        chk({tag, "_ovr"},  n_ovr, exp_ovr);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_data  = 8'h00;
        i_ready = 1'b1;
        #12;
        chk("reset_outputs", {o_data, o_valid, o_last, o_frame_len, o_frame_ok, o_err_len,
                              o_err_chk, o_err_timeout, o_overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Basic good frame; ok pulse and first byte together in the cycle after CHK.
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h03, 8'h69, 1'b1);
        exp_ok++;
        chk("ok_pulse_timing", {31'd0, o_frame_ok}, 32'd1);
        chk("first_byte", {23'd0, o_valid, o_data}, {23'd0, 1'b1, 8'h11});
        wait_idle();
        chk("frame_len_3", o_frame_len, 32'd3);
        check_counts("good_a");

        // Corrupted checksum, then the same frame good.
        send_frame(8'h03, 8'h68, 1'b0);
        exp_chk++;
        chk("chk_pulse_timing", {31'd0, o_err_chk}, 32'd1);
        idle(3);
        chk("no_valid_after_bad", {31'd0, o_valid}, 32'd0);
        send_frame(8'h03, 8'h69, 1'b1);
        exp_ok++;
        wait_idle();
        check_counts("bad_chk");

        // Length limits, then garbage before a one-byte frame.
        send_byte(8'hA5);
        send_byte(8'h00);
        exp_len++;
        chk("len_zero_pulse", {31'd0, o_err_len}, 32'd1);
        send_byte(8'hA5);
        send_byte(8'h11);
        exp_len++;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        pl = '{8'h7E};
        send_frame(8'h01, 8'h7F, 1'b1);
        exp_ok++;
        wait_idle();
        chk("frame_len_1", o_frame_len, 32'd1);
        check_counts("len_err");

        // Inter-byte timeout: pulse exactly after the terminal-count cycle.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        idle(TO);
        chk("to_not_early", {31'd0, o_err_timeout}, 32'd0);
        idle(1);
        exp_to++;
        chk("to_pulse", {31'd0, o_err_timeout}, 32'd1);
        idle(1);
        chk("to_one_cycle", {31'd0, o_err_timeout}, 32'd0);

        // A byte on the terminal-count cycle wins over the timeout.
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h11);
        sb.push_back('{last: 1'b0, dat: 8'h11});
        idle(TO);
        send_byte(8'h22);
        sb.push_back('{last: 1'b0, dat: 8'h22});
        chk("byte_beats_to", {31'd0, o_err_timeout}, 32'd0);
        send_byte(8'h33);
        sb.push_back('{last: 1'b1, dat: 8'h33});
        send_byte(8'h69);
        exp_ok++;
        wait_idle();
        check_counts("timeout");

        // Full-length frame; checksum 16 + sum(10..1F) wraps to 88.
        pl = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
               8'h18, 8'h19, 8'h1A, 8'h1B, 8'h1C, 8'h1D, 8'h1E, 8'h1F};
        send_frame(8'h10, 8'h88, 1'b1);
        exp_ok++;
        idle(3);
        i_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {22'd0, o_valid, o_last, o_data}, {22'd0, 1'b1, 1'b0, 8'h13});
            idle(1);
        end
        i_ready = 1'b1;
        idle(2);
        send_byte(8'h55);
        exp_ovr++;
        chk("overrun_pulse", {31'd0, o_overrun}, 32'd1);
        wait_idle();
        chk("frame_len_16", o_frame_len, 32'd16);
        check_counts("full");

        // Reset in the middle of the payload.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset", {o_data, o_valid, o_last, o_frame_len, o_frame_ok, o_err_len,
                               o_err_chk, o_err_timeout, o_overrun}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        pl = '{8'hAA, 8'h55};
        send_frame(8'h02, 8'h01, 1'b1);
        exp_ok++;
        wait_idle();
        chk("frame_len_2", o_frame_len, 32'd2);
        check_counts("post_reset");
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
